// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stimulus source: accepts a WIDTH-bit word over a valid/ready
// handshake and shifts it out MSB-first, holding each bit for DIV clock cycles.
module piso_serializer #(
    parameter int WIDTH = 8,
    parameter int DIV   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             so,
    output logic             busy,
    output logic             done
);

    localparam int BW = $clog2(WIDTH);
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [BW-1:0] BCNT_LAST = BW'(WIDTH - 1);
    localparam logic [DW-1:0] DCNT_LAST = DW'(DIV - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] sreg;
    logic [DW-1:0]    dcnt;
    logic [BW-1:0]    bcnt;
    logic             last;
    logic             accept;

    // sreg is cleared whenever the word ends without a follow-on, so its MSB is a
    // registered serial output that already reads 0 in IDLE.
    assign so = sreg[WIDTH-1];

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (accept) state_next = SHIFT;
            SHIFT: if (last && !accept) state_next = IDLE;
        endcase
    end

    // load_ready is combinational so a new word can load on the final-bit edge with no gap.
    always_comb begin
        last       = (state == SHIFT) && (bcnt == BCNT_LAST) && (dcnt == DCNT_LAST);
        load_ready = (state == IDLE) || last;
        accept     = load_valid && load_ready;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sreg <= '0;
            dcnt <= '0;
            bcnt <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= last;
            busy <= (state_next == SHIFT);
            if (accept) begin
                sreg <= data;
                dcnt <= '0;
                bcnt <= '0;
            end else if (last) begin
                sreg <= '0;
                dcnt <= '0;
                bcnt <= '0;
            end else if (state == SHIFT) begin
                if (dcnt != DCNT_LAST) begin
                    dcnt <= dcnt + DW'(1);
                end else begin
                    dcnt <= '0;
                    bcnt <= bcnt + BW'(1);
                    sreg <= {sreg[WIDTH-2:0], 1'b0};
                end
            end
        end
    end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in/serial-out stimulus source for the 110 sequence detector. Accepts a WIDTH-bit word over a valid/ready load handshake and shifts it out MSB-first on a single serial line, holding each bit for DIV clock cycles. Its `so` output drives the detector's `si` input directly on the same clock. This replaces free-running random stimulus with deterministic, gapless bit streams.

## Interface
- `WIDTH`, 8: word length in bits; legal range 2..32.
- `DIV`, 1: clock cycles per serial bit; legal range 1..256.
- `clk`  in  1  system clock, rising edge active (100 MHz in the lab setup).
- `reset`  in  1  synchronous, active-high reset; sampled on the rising edge of `clk`.
- `data`  in  WIDTH  parallel word; sampled only on the accept edge.
- `load_valid`  in  1  the producer offers `data`.
- `load_ready`  out  1  combinational; the serializer can accept a word this cycle.
- `so`  out  1  registered serial output; drives the detector's `si`.
- `busy`  out  1  registered; high while a word is being shifted.
- `done`  out  1  registered; one-cycle pulse after the last bit of a word completes.

## Operation
- The FSM has two states, IDLE and SHIFT.
- Internal registers:
  - shift register `sreg[WIDTH-1:0]`;
  - divider counter `dcnt`, running 0..DIV-1;
  - bit counter `bcnt`, running 0..WIDTH-1, with width $clog2(WIDTH).
- `last` = (state==SHIFT) && (bcnt==WIDTH-1) && (dcnt==DIV-1).
- `load_ready` = (state==IDLE) || `last`. This is combinational so the stream can run with no gap.
- Accept = `load_valid` && `load_ready` at a rising edge. On accept:
  - `sreg` <= `data`, `dcnt` <= 0, `bcnt` <= 0;
  - state <= SHIFT, `busy` <= 1.
- `so` is always the MSB of `sreg` while in SHIFT, and 0 in IDLE.
- In SHIFT, when not `last`:
  - if `dcnt` < DIV-1: `dcnt` increments;
  - otherwise `dcnt` <= 0, `bcnt` increments, and `sreg` shifts left with 0 inserted.
- On `last`:
  - `done` <= 1 for one cycle;
  - with an accept on the same edge, the next word loads immediately (state stays SHIFT, `busy` stays 1);
  - without an accept, state <= IDLE, `busy` <= 0, `so` <= 0.
- `load_valid` in SHIFT when not `last` is ignored. The word is not captured, and the producer must hold it until `load_ready`.
- `data` changes while not accepted have no effect.
- `reset` has priority over everything, including an accept on the same edge.

## Timing
- Reset values:
  - `so`=0, `busy`=0, `done`=0;
  - `load_ready`=1, because the FSM is in IDLE;
  - state IDLE, `sreg`=0, `dcnt`=0, `bcnt`=0.
- Accept at edge k: bit i (MSB is i=0) is on `so` from edge k+i·DIV to edge k+(i+1)·DIV.
- Word duration is WIDTH·DIV cycles. The first bit is visible one cycle after the accept edge, so latency is 1.
- `done` is high during the cycle following edge k+WIDTH·DIV.
- With back-to-back accepts, the MSB of the next word follows the LSB of the previous word with zero idle cycles. In that case `busy` never drops.
- Reset mid-word: from the next cycle `so`=0, `busy`=0, `done`=0, and the partial word is discarded. `done` does not pulse for the aborted word.
- With DIV=1, `dcnt` is constant 0 and `last` depends only on `bcnt`.
- The detector samples `si` on the same edge the serializer updates it, so the detector sees bit i one cycle after it appears on `so`. The bench must account for this extra cycle when checking `detected`.

## Test plan
- Reset check:
  - assert `reset` for 3 cycles with `load_valid`=1;
  - expect `so`=0, `busy`=0, `done`=0, `load_ready`=1 throughout;
  - expect no accept while `reset` is high.
- Single word, WIDTH=8, DIV=1, `data`=8'b1101_0110:
  - `so` over cycles 1..8 after accept = 1,1,0,1,0,1,1,0;
  - `done` high in cycle 9 and `busy` low from cycle 9;
  - the detector pulses `detected` exactly twice, once for each "110".
- Back-to-back, DIV=1:
  - hold `load_valid`=1 with 8'hA5 then 8'h3C;
  - expect 16 contiguous bits 1010_0101_0011_1100;
  - `load_ready` high only in the `last` cycle of the first word;
  - `busy` continuously high for 16 cycles;
  - `done` pulses at cycles 9 and 17.
- DIV=4, `data`=8'h81:
  - `so` is 1 for 4 cycles, 0 for 24 cycles, then 1 for 4 cycles, 32 cycles total;
  - `done` pulses once at cycle 33.
- Load while busy:
  - accept 8'hFF, then pulse `load_valid` with 8'h00 for 2 cycles at bit 3;
  - expect the 8'h00 word ignored, 8 ones on `so`, and a return to IDLE.
- Reset mid-word:
  - assert `reset` during bit 4 of 8'hF0;
  - expect `so`=0 and `busy`=0 on the next cycle and no `done` pulse;
  - a new accept after reset then shifts correctly from its MSB.
